pe_row_datapath: RTL and testbench
==================================

// Module: pe_row_datapath
// PURPOSE
// - Parametrised successor to the single-MAC convolution datapath.
// - A row of NB_PE MAC units shares one activation and applies NB_PE weights in parallel, one output channel per PE.
// - Partial sums live in internal accumulators, so no external-memory round trip is needed.
// - Results are scaled, then serialised one channel per beat onto a ready/valid output stream.
// PARAMETERS
// - IO_DATA_WIDTH       16   signed activation, weight and output width
// - ACCUMULATION_WIDTH  32   per-PE accumulator width
// - NB_PE               4    parallel PEs = output channels per pass (>=1)
// - MAX_K               576  max accumulation terms per output (64 ch * 3*3)
// - OUTPUT_SCALE        0    arithmetic right shift applied before output narrowing
// PORTS
// - clk           in   1                      clock
// - arst_n_in     in   1                      async reset, active low
// - start         in   1                      begin a pass (sampled in IDLE only)
// - k_total       in   $clog2(MAX_K+1)        terms per output; sampled with start
// - running       out  1                      high whenever state != IDLE
// - done          out  1                      1-cycle pulse after the last output beat
// - a_input       in   IO_DATA_WIDTH          activation data
// - a_valid       in   1                      activation valid
// - a_ready       out  1                      activation ready
// - b_input       in   IO_DATA_WIDTH          weight data
// - b_valid       in   1                      weight valid
// - b_ready       out  1                      weight ready
// - out           out  IO_DATA_WIDTH          scaled result, signed
// - output_valid  out  1                      result valid
// - output_ready  in   1                      downstream ready
// - output_ch     out  $clog2(NB_PE) (min 1)  channel index of the current output beat
// BEHAVIOUR
// - Reset (async, arst_n_in=0): state=IDLE; all w[], acc[] and counters cleared.
//   - Outputs: running=0, done=0, a_ready=0, b_ready=0, output_valid=0, out=0, output_ch=0.
//   - A reset mid-pass aborts the pass immediately; no partial output is emitted.
// - Handshake rule: a transfer occurs on a cycle where valid&&ready.
//   - ready never depends combinationally on valid.
//   - output_valid, once high, stays high and out/output_ch stay stable until output_ready.
// - FSM states: IDLE -> LOAD_W -> MAC -> (LOAD_W | DRAIN) -> IDLE.
//   - IDLE: start && k_total!=0 -> LOAD_W; latch k_total; step=0.
//     - start with k_total==0 is ignored (stay IDLE).
//     - start outside IDLE is ignored.
//   - LOAD_W: b_ready=1. Each b transfer writes w[widx] and increments widx.
//     - The transfer at widx==NB_PE-1 -> MAC; widx=0.
//   - MAC: a_ready=1. On an a transfer, every PE i computes in the same cycle:
//     - acc[i] <= (step==0 ? 0 : acc[i]) + a*w[i]
//     - Then, if step==k_lat-1 -> DRAIN with ch=0; else step++ -> LOAD_W.
//   - DRAIN: output_valid=1; out=narrow(acc[ch]>>>OUTPUT_SCALE); output_ch=ch.
//     - On each transfer ch++. The transfer at ch==NB_PE-1 -> IDLE and pulses done next cycle.
// - Latency: first output_valid appears 1 cycle after the last a transfer.
//   - Throughput is one beat per cycle under no backpressure.
//   - Per step: NB_PE weight beats + 1 activation beat.
// - Arithmetic: the signed IO*IO product (2*IO_DATA_WIDTH bits) is sign-extended to ACCUMULATION_WIDTH.
//   - The accumulator wraps two's-complement on overflow; no flag is raised.
//   - Shift is arithmetic (sign-preserving).
// - a_valid while not in MAC and b_valid while not in LOAD_W are ignored; no data is consumed.
// CONFIGURATION
// - Macro PE_ROW_SATURATE_EN
//   - Defined: narrow() clamps the shifted value to [-2^(IO-1), 2^(IO-1)-1].
//   - Undefined: narrow() keeps the low IO_DATA_WIDTH bits (truncation, wraps).
//   - All other behaviour is identical in both builds.
// TESTING
// - Defaults; k=1; w={1,2,-3,4}, a=3 -> out 3,6,-9,12 on output_ch 0..3; done pulses once.
// - k=3; w={1,1,1,1} each step; a=5,-2,7 -> all four outputs = 10.
// - Backpressure: output_ready=0 for 5 cycles in DRAIN -> out and output_ch held; no beat lost or duplicated.
// - k=1, w0=200, a=200 -> acc=40000 -> out=32767 with PE_ROW_SATURATE_EN, -25536 without.
// - arst_n_in pulsed mid-MAC (step 2 of 3) -> all outputs at reset values; next pass with k=1 gives clean results.
// - start during running, and start with k_total=0 -> both ignored; no state change, no handshakes.

Source files
------------

// File: rtl/pe_row_datapath.sv
// pe_row_datapath: row of NB_PE MAC units sharing one activation, results serialised one channel per beat.
// Define PE_ROW_SATURATE_EN to clamp (instead of wrap) when narrowing the scaled accumulator to the output width.
module pe_row_datapath #(
  parameter int IO_DATA_WIDTH      = 16,
  parameter int ACCUMULATION_WIDTH = 32,
  parameter int NB_PE              = 4,
  parameter int MAX_K              = 576,
  parameter int OUTPUT_SCALE       = 0,
  localparam int KW = $clog2(MAX_K + 1),
  localparam int CW = NB_PE > 1 ? $clog2(NB_PE) : 1
) (
  input  logic                            clk,
  input  logic                            arst_n_in,
  input  logic                            start,
  input  logic [KW-1:0]                   k_total,
  output logic                            running,
  output logic                            done,
  input  logic signed [IO_DATA_WIDTH-1:0] a_input,
  input  logic                            a_valid,
  output logic                            a_ready,
  input  logic signed [IO_DATA_WIDTH-1:0] b_input,
  input  logic                            b_valid,
  output logic                            b_ready,
  output logic signed [IO_DATA_WIDTH-1:0] out,
  output logic                            output_valid,
  input  logic                            output_ready,
  output logic [CW-1:0]                   output_ch
);
  localparam logic [CW-1:0] LAST = CW'(NB_PE - 1);
  typedef enum logic [1:0] {IDLE, LOAD_W, MAC, DRAIN} state_t;
  state_t state, state_nx;
  logic [KW-1:0] k_lat, step;
  logic [CW-1:0] widx, ch;
  logic signed [IO_DATA_WIDTH-1:0] w [NB_PE];
  logic signed [ACCUMULATION_WIDTH-1:0] acc [NB_PE];
  logic signed [2*IO_DATA_WIDTH-1:0] prod [NB_PE];
  logic signed [ACCUMULATION_WIDTH-1:0] shifted;
  logic signed [IO_DATA_WIDTH-1:0] narrowed;
  logic a_fire, b_fire, o_fire, go, last_step;
  assign running      = state != IDLE;
  assign b_ready      = state == LOAD_W;
  assign a_ready      = state == MAC;
  assign output_valid = state == DRAIN;
  assign output_ch    = ch;
  assign a_fire       = a_valid && a_ready;
  assign b_fire       = b_valid && b_ready;
  assign o_fire       = output_valid && output_ready;
  assign go           = state == IDLE && start && k_total != '0;
  assign last_step    = step == k_lat - KW'(1);
  for (genvar i = 0; i < NB_PE; i++) begin : g_pe
    assign prod[i] = a_input * w[i];
  end
  assign shifted = acc[ch] >>> OUTPUT_SCALE;
`ifdef PE_ROW_SATURATE_EN
  localparam logic signed [ACCUMULATION_WIDTH-1:0] SAT_HI = ACCUMULATION_WIDTH'((2 ** (IO_DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACCUMULATION_WIDTH-1:0] SAT_LO = ~SAT_HI;
  assign narrowed = shifted > SAT_HI ? IO_DATA_WIDTH'(SAT_HI) :
                    shifted < SAT_LO ? IO_DATA_WIDTH'(SAT_LO) : IO_DATA_WIDTH'(shifted);
`else
  assign narrowed = IO_DATA_WIDTH'(shifted);
`endif
  assign out = output_valid ? narrowed : '0;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = go ? LOAD_W : IDLE;
      LOAD_W:  state_nx = b_fire && widx == LAST ? MAC : LOAD_W;
      MAC:     state_nx = a_fire ? (last_step ? DRAIN : LOAD_W) : MAC;
      DRAIN:   state_nx = o_fire && ch == LAST ? IDLE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state <= IDLE;
      k_lat <= '0;
      step  <= '0;
      widx  <= '0;
      ch    <= '0;
      done  <= 1'b0;
      for (int i = 0; i < NB_PE; i++) begin
        w[i]   <= '0;
        acc[i] <= '0;
      end
    end else begin
      state <= state_nx;
      done  <= o_fire && ch == LAST;
      if (go) begin
        k_lat <= k_total;
        step  <= '0;
      end
      if (b_fire) begin
        w[widx] <= b_input;
        widx    <= widx == LAST ? '0 : widx + CW'(1);
      end
      // step 0 restarts every accumulator, so no separate clear pass is needed
      if (a_fire) begin
        for (int i = 0; i < NB_PE; i++)
          acc[i] <= (step == '0 ? '0 : acc[i]) + ACCUMULATION_WIDTH'(prod[i]);
        step <= last_step ? step : step + KW'(1);
        if (last_step) ch <= '0;
      end
      if (o_fire) ch <= ch == LAST ? '0 : ch + CW'(1);
    end
  end
endmodule

// File: tb/tb_pe_row_datapath.sv
// tb_pe_row_datapath: directed vectors for the default 4-PE row; expectations follow PE_ROW_SATURATE_EN.
module tb_pe_row_datapath;
  logic clk = 0, arst_n_in = 0, start = 0, a_valid = 0, b_valid = 0, output_ready = 0;
  logic [9:0] k_total = '0;
  logic signed [15:0] a_input = '0, b_input = '0;
  logic running, done, a_ready, b_ready, output_valid;
  logic signed [15:0] out;
  logic [1:0] output_ch;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  pe_row_datapath dut (
    .clk(clk), .arst_n_in(arst_n_in), .start(start), .k_total(k_total),
    .running(running), .done(done),
    .a_input(a_input), .a_valid(a_valid), .a_ready(a_ready),
    .b_input(b_input), .b_valid(b_valid), .b_ready(b_ready),
    .out(out), .output_valid(output_valid), .output_ready(output_ready), .output_ch(output_ch)
  );
  task automatic push_b(input logic signed [15:0] v);
    int n = 0;
    b_input = v; b_valid = 1;
    while (!b_ready && n < 50) begin @(posedge clk); #1; n++; end
    total++;
    if (n >= 50) begin bad++; $display("FAIL b_timeout b_ready=%b required 1", b_ready); end
    @(posedge clk); #1;
    b_valid = 0;
  endtask
  task automatic push_a(input logic signed [15:0] v);
    int n = 0;
    a_input = v; a_valid = 1;
    while (!a_ready && n < 50) begin @(posedge clk); #1; n++; end
    total++;
    if (n >= 50) begin bad++; $display("FAIL a_timeout a_ready=%b required 1", a_ready); end
    @(posedge clk); #1;
    a_valid = 0;
  endtask
  task automatic push_step(input logic signed [15:0] w0, w1, w2, w3, a);
    push_b(w0); push_b(w1); push_b(w2); push_b(w3); push_a(a);
  endtask
  task automatic kick(input logic [9:0] k);
    start = 1; k_total = k;
    @(posedge clk); #1;
    start = 0; k_total = '0;
  endtask
  task automatic test_reset;
    arst_n_in = 0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({running, done, a_ready, b_ready, output_valid, out, output_ch} !== '0)
      begin bad++; $display("FAIL reset outputs=%h required 0", {running, done, a_ready, b_ready, output_valid, out, output_ch}); end
    arst_n_in = 1;
    @(posedge clk); #1;
  endtask
  task automatic test_basic;
    logic signed [15:0] e [4] = '{16'sd3, 16'sd6, -16'sd9, 16'sd12};
    kick(1);
    total++;
    if (running !== 1 || b_ready !== 1) begin bad++; $display("FAIL basic_start running=%b b_ready=%b required 1 1", running, b_ready); end
    push_step(1, 2, -3, 4, 3);
    total++;
    if (output_valid !== 1) begin bad++; $display("FAIL basic_latency valid=%b required 1", output_valid); end
    output_ready = 1;
    for (int c = 0; c < 4; c++) begin
      total++;
      if (output_valid !== 1 || out !== e[c] || output_ch !== 2'(c))
        begin bad++; $display("FAIL basic_beat%0d out=%0d ch=%0d valid=%b required %0d %0d 1", c, out, output_ch, output_valid, e[c], c); end
      @(posedge clk); #1;
    end
    output_ready = 0;
    total++;
    if (done !== 1 || running !== 0 || output_valid !== 0)
      begin bad++; $display("FAIL basic_done done=%b running=%b valid=%b required 1 0 0", done, running, output_valid); end
    @(posedge clk); #1;
    total++;
    if (done !== 0) begin bad++; $display("FAIL basic_done_pulse done=%b required 0", done); end
  endtask
  task automatic test_accumulate;
    kick(3);
    push_step(1, 1, 1, 1, 5);
    push_step(1, 1, 1, 1, -2);
    push_step(1, 1, 1, 1, 7);
    output_ready = 1;
    for (int c = 0; c < 4; c++) begin
      total++;
      if (output_valid !== 1 || out !== 16'sd10 || output_ch !== 2'(c))
        begin bad++; $display("FAIL accum_beat%0d out=%0d ch=%0d valid=%b required 10 %0d 1", c, out, output_ch, output_valid, c); end
      @(posedge clk); #1;
    end
    output_ready = 0;
    total++;
    if (done !== 1) begin bad++; $display("FAIL accum_done done=%b required 1", done); end
  endtask
  task automatic test_backpressure;
    logic signed [15:0] e [4] = '{-16'sd28, 16'sd4, 16'sd0, -16'sd400};
    int hold [4] = '{5, 0, 2, 0};
    kick(1);
    push_step(7, -1, 0, 100, -4);
    for (int c = 0; c < 4; c++) begin
      for (int h = 0; h < hold[c]; h++) begin
        total++;
        if (output_valid !== 1 || out !== e[c] || output_ch !== 2'(c) || done !== 0)
          begin bad++; $display("FAIL bp_hold%0d_%0d out=%0d ch=%0d valid=%b required %0d %0d 1", c, h, out, output_ch, output_valid, e[c], c); end
        @(posedge clk); #1;
      end
      output_ready = 1;
      total++;
      if (output_valid !== 1 || out !== e[c] || output_ch !== 2'(c))
        begin bad++; $display("FAIL bp_beat%0d out=%0d ch=%0d valid=%b required %0d %0d 1", c, out, output_ch, output_valid, e[c], c); end
      @(posedge clk); #1;
      output_ready = 0;
    end
    total++;
    if (done !== 1 || output_valid !== 0) begin bad++; $display("FAIL bp_done done=%b valid=%b required 1 0", done, output_valid); end
  endtask
  task automatic test_saturate;
`ifdef PE_ROW_SATURATE_EN
    logic signed [15:0] e [4] = '{16'sd32767, -16'sd32768, 16'sd200, 16'sd0};
`else
    logic signed [15:0] e [4] = '{-16'sd25536, 16'sd25536, 16'sd200, 16'sd0};
`endif
    kick(1);
    push_step(200, -200, 1, 0, 200);
    output_ready = 1;
    for (int c = 0; c < 4; c++) begin
      total++;
      if (output_valid !== 1 || out !== e[c] || output_ch !== 2'(c))
        begin bad++; $display("FAIL narrow_beat%0d out=%0d ch=%0d required %0d %0d", c, out, output_ch, e[c], c); end
      @(posedge clk); #1;
    end
    output_ready = 0;
  endtask
  task automatic test_reset_mid;
    logic signed [15:0] e [4] = '{16'sd3, 16'sd6, -16'sd9, 16'sd12};
    kick(3);
    push_step(1, 1, 1, 1, 5);
    push_step(1, 1, 1, 1, -2);
    push_b(9); push_b(9); push_b(9); push_b(9);
    total++;
    if (a_ready !== 1) begin bad++; $display("FAIL mid_in_mac a_ready=%b required 1", a_ready); end
    #2 arst_n_in = 0;
    #1;
    total++;
    if ({running, done, a_ready, b_ready, output_valid, out, output_ch} !== '0)
      begin bad++; $display("FAIL mid_reset outputs=%h required 0", {running, done, a_ready, b_ready, output_valid, out, output_ch}); end
    @(posedge clk); #1;
    arst_n_in = 1;
    @(posedge clk); #1;
    total++;
    if (running !== 0 || output_valid !== 0) begin bad++; $display("FAIL mid_idle running=%b valid=%b required 0 0", running, output_valid); end
    kick(1);
    push_step(1, 2, -3, 4, 3);
    output_ready = 1;
    for (int c = 0; c < 4; c++) begin
      total++;
      if (output_valid !== 1 || out !== e[c] || output_ch !== 2'(c))
        begin bad++; $display("FAIL mid_after_beat%0d out=%0d ch=%0d required %0d %0d", c, out, output_ch, e[c], c); end
      @(posedge clk); #1;
    end
    output_ready = 0;
  endtask
  task automatic test_ignored;
    start = 1; k_total = '0; a_valid = 1; b_valid = 1; a_input = 55; b_input = 66;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (running !== 0 || a_ready !== 0 || b_ready !== 0 || output_valid !== 0)
        begin bad++; $display("FAIL k0_ignored%0d running=%b a_ready=%b b_ready=%b required 0 0 0", i, running, a_ready, b_ready); end
    end
    start = 0; a_valid = 0; b_valid = 0;
    kick(1);
    push_b(2);
    start = 1; k_total = 10'd5; a_valid = 1; a_input = 100;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      total++;
      if (running !== 1 || a_ready !== 0 || b_ready !== 1)
        begin bad++; $display("FAIL busy_start%0d running=%b a_ready=%b b_ready=%b required 1 0 1", i, running, a_ready, b_ready); end
    end
    start = 0; k_total = '0; a_valid = 0;
    push_b(2); push_b(2); push_b(2);
    push_a(3);
    total++;
    if (output_valid !== 1) begin bad++; $display("FAIL busy_k_kept valid=%b required 1", output_valid); end
    output_ready = 1;
    for (int c = 0; c < 4; c++) begin
      total++;
      if (output_valid !== 1 || out !== 16'sd6 || output_ch !== 2'(c))
        begin bad++; $display("FAIL busy_beat%0d out=%0d ch=%0d required 6 %0d", c, out, output_ch, c); end
      @(posedge clk); #1;
    end
    output_ready = 0;
  endtask
  initial begin
    test_reset;
    test_basic;
    test_accumulate;
    test_backpressure;
    test_saturate;
    test_reset_mid;
    test_ignored;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
